sqrt_fx_hs: RTL and testbench

- Fixed-point unsigned square-root unit. Next generation of the single-radicand iterative sqrt.
- Resolves ITER_PER_CYCLE result bits per clock, so area and latency trade off through one parameter.
- Uses a valid/ready handshake on both input and output, carries a tag through, and supports a synchronous abort.
- Sits between the Q-format datapath producers and consumers; one computation in flight at a time.

---
 rtl/sqrt_fx_pkg.sv | 26 ++
 rtl/sqrt_fx_step.sv | 33 +++
 rtl/sqrt_fx_hs.sv | 140 ++++++++++++++
 tb/tb_sqrt_fx_hs.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_fx_pkg.sv
// Shared types and sizing helpers for the fixed-point square-root unit.
package sqrt_fx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One root bit per radicand bit pair of the F_BITS-extended radicand.
    function automatic int iters(input int width, input int f_bits);
        return (width + f_bits) / 2;
    endfunction

    function automatic int rem_w(input int n_iters);
        return n_iters + 2;
    endfunction

    function automatic int root_w(input int n_iters);
        return n_iters;
    endfunction

    localparam int DEF_ITERS = iters(48, 28);

endpackage

// File: rtl/sqrt_fx_step.sv
// One restoring square-root recurrence step: brings in the next radicand bit pair, resolves one root bit.
// Purely combinational; no handshake.
module sqrt_fx_step
    import sqrt_fx_pkg::*;
#(
    parameter int ITERS = DEF_ITERS
) (
    input  logic [rem_w(ITERS)-1:0]  rem_in,
    input  logic [root_w(ITERS)-1:0] root_in,
    input  logic [1:0]               pair,
    output logic [rem_w(ITERS)-1:0]  rem_out,
    output logic [root_w(ITERS)-1:0] root_out
);

    localparam int RW = rem_w(ITERS);
    localparam int TW = RW + 2;

    logic [TW-1:0] shifted;
    logic [TW-1:0] sub;
    logic [TW:0]   diff;
    logic          ge;

    always_comb begin
        shifted = {rem_in, pair};
        sub     = {2'b00, root_in, 2'b01};
        diff    = {1'b0, shifted} - {1'b0, sub};
        ge      = ~diff[TW];
        // Upper bits of the kept value are zero because rem never exceeds 2*root.
        rem_out  = RW'(ge ? diff[TW-1:0] : shifted);
        root_out = {root_in[ITERS-2:0], ge};
    end

endmodule

// File: rtl/sqrt_fx_hs.sv
// Iterative unsigned Q-format square root, ITER_PER_CYCLE root bits per clock; optional rounding via SQRT_ROUND_EN.
// Latency: accept edge + ITERS/ITER_PER_CYCLE edges (+1 with SQRT_ROUND_EN).
// Backpressure: single computation in flight; result held in DONE until out_ready, in_ready only in IDLE.
module sqrt_fx_hs
    import sqrt_fx_pkg::*;
#(
    parameter int WIDTH          = 48,
    parameter int F_BITS         = 28,
    parameter int ITER_PER_CYCLE = 2,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_radicand,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_root,
    output logic [WIDTH-1:0] out_rem,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int ITERS  = iters(WIDTH, F_BITS);
    localparam int RW     = rem_w(ITERS);
    localparam int QW     = root_w(ITERS);
    localparam int XW     = 2 * ITERS;
    localparam int CYCLES = ITERS / ITER_PER_CYCLE;
    localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    if ((WIDTH + F_BITS) % 2 != 0) begin : g_chk_even
        $error("sqrt_fx_hs: WIDTH+F_BITS must be even");
    end
    if (ITERS % ITER_PER_CYCLE != 0) begin : g_chk_ipc
        $error("sqrt_fx_hs: ITER_PER_CYCLE must divide (WIDTH+F_BITS)/2");
    end
    if (RW > WIDTH) begin : g_chk_fit
        $error("sqrt_fx_hs: remainder does not fit in WIDTH");
    end

`ifdef SQRT_ROUND_EN
    localparam state_t CALC_EXIT = ROUND;
`else
    localparam state_t CALC_EXIT = DONE;
`endif

    state_t           state_q, state_d;
    logic [XW-1:0]    rad_q;
    logic [RW-1:0]    rem_q;
    logic [QW-1:0]    root_q;
    logic [CW-1:0]    cnt_q;
    logic [TAG_W-1:0] tag_q;
    logic             last;

    logic [RW-1:0] rem_c  [ITER_PER_CYCLE+1];
    logic [QW-1:0] root_c [ITER_PER_CYCLE+1];

    assign rem_c[0]  = rem_q;
    assign root_c[0] = root_q;

    for (genvar k = 0; k < ITER_PER_CYCLE; k++) begin : g_step
        sqrt_fx_step #(.ITERS(ITERS)) u_step (
            .rem_in   (rem_c[k]),
            .root_in  (root_c[k]),
            .pair     (rad_q[XW-1-2*k -: 2]),
            .rem_out  (rem_c[k+1]),
            .root_out (root_c[k+1])
        );
    end

    assign last      = (cnt_q == '0);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == ROUND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:    if (last)      state_d = CALC_EXIT;
            ROUND:                  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            tag_q    <= '0;
            out_root <= '0;
            out_rem  <= '0;
            out_tag  <= '0;
        end else if (!clear) begin
            if (state_q == IDLE && in_valid) begin
                rad_q  <= {in_radicand, {F_BITS{1'b0}}};
                rem_q  <= '0;
                root_q <= '0;
                cnt_q  <= CW'(CYCLES - 1);
                tag_q  <= in_tag;
            end else if (state_q == CALC) begin
                rad_q  <= rad_q << (2 * ITER_PER_CYCLE);
                rem_q  <= rem_c[ITER_PER_CYCLE];
                root_q <= root_c[ITER_PER_CYCLE];
                cnt_q  <= cnt_q - CW'(1);
`ifndef SQRT_ROUND_EN
                if (last) begin
                    out_root <= WIDTH'(root_c[ITER_PER_CYCLE]);
                    out_rem  <= WIDTH'(rem_c[ITER_PER_CYCLE]);
                    out_tag  <= tag_q;
                end
`endif
            end
`ifdef SQRT_ROUND_EN
            // rem > root means radicand lies past (root+0.5)^2, so round up.
            if (state_q == ROUND) begin
                out_root <= WIDTH'(root_q) + WIDTH'(rem_q > RW'(root_q));
                out_rem  <= WIDTH'(rem_q);
                out_tag  <= tag_q;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sqrt_fx_hs.sv
// Scoreboard bench for sqrt_fx_hs: directed radicands with hand-computed roots plus identity checks.
module tb_sqrt_fx_hs;

    localparam int WIDTH = 48;
    localparam int F_BITS = 28;
    localparam int IPC = 2;
    localparam int TAG_W = 4;
    localparam int ITERS = (WIDTH + F_BITS) / 2;
`ifdef SQRT_ROUND_EN
    localparam int CYC = ITERS / IPC + 1;
`else
    localparam int CYC = ITERS / IPC;
`endif

    logic             clk;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_radicand;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_root;
    logic [WIDTH-1:0] out_rem;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    sqrt_fx_hs #(
        .WIDTH(WIDTH), .F_BITS(F_BITS), .ITER_PER_CYCLE(IPC), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_radicand(in_radicand), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_root(out_root), .out_rem(out_rem), .out_tag(out_tag),
        .busy(busy)
    );

    typedef struct {
        logic [WIDTH-1:0] rad;
        logic [TAG_W-1:0] tag;
        bit               known;
        logic [WIDTH-1:0] root;
        logic [WIDTH-1:0] rem;
        int               acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] rad, input logic [TAG_W-1:0] tag, input bit push,
                        input bit known, input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] em);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        in_valid    = 1'b1;
        in_radicand = rad;
        in_tag      = tag;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
            in_valid = 1'b0;
        end else begin
            if (push) begin
                e.rad = rad; e.tag = tag; e.known = known;
                e.root = er; e.rem = em; e.acc = cyc + 1;
                q.push_back(e);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: queue=%0d in_ready=%0b, expected 0 and 1", q.size(), in_ready);
        end
        @(negedge clk);
    endtask

    // Monitor: new result on each out_valid rise, stability while held.
    initial begin
        bit               have;
        exp_t             e;
        logic [WIDTH-1:0] s_root, s_rem;
        logic [TAG_W-1:0] s_tag;
        logic [127:0]     x, rt, rm;
        have = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !out_valid) begin
                have = 1'b0;
            end else if (!have) begin
                have = 1'b1;
                s_root = out_root; s_rem = out_rem; s_tag = out_tag;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: out_valid=1 tag=%0d, expected no result", out_tag);
                end else begin
                    e = q.pop_front();
                    chk("latency", 128'(cyc - e.acc), 128'(CYC));
                    chk("tag", 128'(out_tag), 128'(e.tag));
                    chk("in_ready_in_done", 128'(in_ready), 128'(0));
                    if (e.known) begin
                        chk("root", 128'(out_root), 128'(e.root));
                        chk("rem", 128'(out_rem), 128'(e.rem));
                    end
                    x  = 128'(e.rad) << F_BITS;
                    rt = 128'(out_root);
                    rm = 128'(out_rem);
`ifdef SQRT_ROUND_EN
                    if (rt * rt > x) rt = rt - 128'(1);
                    chk("round_rule", 128'(out_root), rt + 128'(rm > rt));
`else
                    chk("root_upper_zero", 128'(out_root) >> ITERS, 128'(0));
`endif
                    chk("identity", rt * rt + rm, x);
                    chk("rem_le_2root", 128'(rm <= 128'(2) * rt), 128'(1));
                end
            end else begin
                chk("hold_stable", 128'((out_root == s_root) && (out_rem == s_rem) && (out_tag == s_tag)), 128'(1));
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] r;
        int n;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_radicand = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_outputs", 128'({out_root, out_rem, out_tag}), 128'(0));
        rst = 1'b0;

        send(48'h4_0000_0000, 4'd1, 1, 1, 48'h8000_0000, 48'h0);
        send(48'h400_0000,    4'd2, 1, 1, 48'h800_0000,  48'h0);
        send(48'h0,           4'd3, 1, 1, 48'h0,         48'h0);
        send(48'h2000_0000,   4'd4, 1, 1, 48'd379625062, 48'd377352028);
        send({WIDTH{1'b1}},   4'd5, 1, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            r = 48'({$urandom(), $urandom()});
            send(r, 4'(i + 10), 1, 0, '0, '0);
        end
        wait_idle();

        // Backpressure: result held 10 cycles while a second input waits.
        out_ready = 1'b0;
        send(48'h400_0000, 4'd6, 1, 1, 48'h800_0000, 48'h0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", 128'(out_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_radicand = 48'h4_0000_0000; in_tag = 4'd7;
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        send(48'h4_0000_0000, 4'd7, 1, 1, 48'h8000_0000, 48'h0);
        wait_idle();

        // Abort at the 7th CALC cycle.
        send(48'h2000_0000, 4'd8, 0, 0, '0, '0);
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_busy", 128'(busy), 128'(0));
        chk("clr_in_ready", 128'(in_ready), 128'(1));
        repeat (30) @(negedge clk);
        send(48'h4_0000_0000, 4'd9, 1, 1, 48'h8000_0000, 48'h0);
        wait_idle();

        // in_valid with clear in IDLE is not accepted.
        clear = 1'b1; in_valid = 1'b1; in_radicand = 48'h400_0000; in_tag = 4'd3;
        @(negedge clk);
        chk("clr_idle_busy", 128'(busy), 128'(0));
        chk("clr_idle_in_ready", 128'(in_ready), 128'(1));
        clear = 1'b0; in_valid = 1'b0;

        // Asynchronous reset mid-CALC.
        send(48'h2000_0000, 4'd12, 0, 0, '0, '0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_outputs", 128'({out_root, out_rem, out_tag}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        send(48'h400_0000, 4'd13, 1, 1, 48'h800_0000, 48'h0);
        wait_idle();

        chk("queue_empty", 128'(q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
